// File: rtl/key_flag_gen.sv
// key_flag_gen: four-key front end for the paddle logic.
// Each raw, bouncing, active-low button is synchronized, debounced and
// turned into a one-cycle move strobe. A key that stays down also
// produces auto-repeat strobes.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active high
//   key_n[3:0] raw buttons, active low; bit i drives key_flag(i+1)
//   key_flag1..key_flag4  one-cycle press/repeat strobes, registered
//   key_state[3:0]        debounced pressed level (1 = pressed), registered

// One key: 2-FF synchronizer followed by the debounce/repeat FSM.
module key_flag_lane #(
  parameter int DEBOUNCE_CYC   = 1_000_000,
  parameter int REPEAT_DLY_CYC = 25_000_000,
  parameter int REPEAT_CYC     = 5_000_000,
  parameter bit REPEAT_EN      = 1'b1,
  parameter int CW             = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic flag,
  output logic state
);
  typedef enum logic [2:0] {IDLE, PRESS_DB, HELD, REPEAT, REL_DB} st_e;

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DLY_CYC - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_CYC - 1);

  logic [1:0]    sync_q;
  st_e           st;
  logic [CW-1:0] cnt;
  logic          p;

  assign p = ~sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;   // released
      st     <= IDLE;
      cnt    <= '0;
      flag   <= 1'b0;
      state  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_n};
      flag   <= 1'b0;
      unique case (st)
        IDLE: begin
          cnt <= '0;
          if (p) st <= PRESS_DB;
        end
        PRESS_DB: begin
          if (!p) begin
            st  <= IDLE;
            cnt <= '0;
          end else if (cnt == DB_LAST) begin
            st    <= HELD;
            flag  <= 1'b1;
            state <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Release is tested first so it always wins over a strobe.
        HELD: begin
          if (!p) begin
            st  <= REL_DB;
            cnt <= '0;
          end else if (REPEAT_EN && cnt == RD_LAST) begin
            st   <= REPEAT;
            flag <= 1'b1;
            cnt  <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;   // saturates when repeat is off
          end
        end
        REPEAT: begin
          if (!p) begin
            st  <= REL_DB;
            cnt <= '0;
          end else if (cnt == RP_LAST) begin
            flag <= 1'b1;
            cnt  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // A bounce back to pressed resumes HELD with a fresh repeat delay.
        REL_DB: begin
          if (p) begin
            st  <= HELD;
            cnt <= '0;
          end else if (cnt == DB_LAST) begin
            st    <= IDLE;
            state <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          st    <= IDLE;
          state <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

module key_flag_gen #(
  parameter int DEBOUNCE_CYC   = 1_000_000,
  parameter int REPEAT_DLY_CYC = 25_000_000,
  parameter int REPEAT_CYC     = 5_000_000,
  parameter bit REPEAT_EN      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_n,
  output logic       key_flag1,
  output logic       key_flag2,
  output logic       key_flag3,
  output logic       key_flag4,
  output logic [3:0] key_state
);
  localparam int NUM_LANES = 4;
  // Counter only ever reaches (largest parameter - 1).
  localparam int MAX_A = (DEBOUNCE_CYC > REPEAT_DLY_CYC) ? DEBOUNCE_CYC : REPEAT_DLY_CYC;
  localparam int MAX_P = (MAX_A > REPEAT_CYC) ? MAX_A : REPEAT_CYC;
  localparam int CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  logic [NUM_LANES-1:0] flag;

  key_flag_lane #(
    .DEBOUNCE_CYC  (DEBOUNCE_CYC),
    .REPEAT_DLY_CYC(REPEAT_DLY_CYC),
    .REPEAT_CYC    (REPEAT_CYC),
    .REPEAT_EN     (REPEAT_EN),
    .CW            (CW)
  ) u_lane [NUM_LANES-1:0] (
    .clk  (clk),
    .rst  (rst),
    .key_n(key_n),
    .flag (flag),
    .state(key_state)
  );

  assign key_flag1 = flag[0];
  assign key_flag2 = flag[1];
  assign key_flag3 = flag[2];
  assign key_flag4 = flag[3];
endmodule

// File: tb/tb_key_flag_gen.sv
module tb_key_flag_gen;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RC = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_n = 4'b0000;
  logic       key_flag1, key_flag2, key_flag3, key_flag4;
  logic [3:0] key_state;

  key_flag_gen #(
    .DEBOUNCE_CYC  (DB),
    .REPEAT_DLY_CYC(RD),
    .REPEAT_CYC    (RC),
    .REPEAT_EN     (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_n    (key_n),
    .key_flag1(key_flag1),
    .key_flag2(key_flag2),
    .key_flag3(key_flag3),
    .key_flag4(key_flag4),
    .key_state(key_state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: per key, count consecutive sampled levels and the
  // age of the hold since the last strobe / bounce, and decide strobes
  // from those run lengths.
  bit   hist1 [4];
  bit   hist2 [4];
  bit   down  [4];
  bit   rep   [4];
  int   press_run [4];
  int   rel_run   [4];
  int   age       [4];
  logic [3:0] exp_flag, exp_state;
  int   pulses [4];

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      hist1[i] = 1'b1; hist2[i] = 1'b1;
      down[i] = 1'b0; rep[i] = 1'b0;
      press_run[i] = 0; rel_run[i] = 0; age[i] = 0;
    end
    exp_flag  = '0;
    exp_state = '0;
  endfunction

  function automatic void model_step(input logic [3:0] kn);
    for (int i = 0; i < 4; i++) begin
      bit p;
      p = !hist2[i];          // key level sampled two edges ago
      hist2[i] = hist1[i];
      hist1[i] = kn[i];
      exp_flag[i] = 1'b0;
      if (!down[i]) begin
        if (p) begin
          press_run[i]++;
          if (press_run[i] == DB + 1) begin
            down[i] = 1'b1; rep[i] = 1'b0; age[i] = 0; rel_run[i] = 0;
            exp_flag[i] = 1'b1;
          end
        end else press_run[i] = 0;
      end else begin
        if (!p) begin
          rel_run[i]++;
          if (rel_run[i] == DB + 1) begin
            down[i] = 1'b0; press_run[i] = 0;
          end
        end else if (rel_run[i] > 0) begin
          rel_run[i] = 0; rep[i] = 1'b0; age[i] = 0;
        end else begin
          age[i]++;
          if (age[i] == (rep[i] ? RC : RD)) begin
            exp_flag[i] = 1'b1; rep[i] = 1'b1; age[i] = 0;
          end
        end
      end
      exp_state[i] = down[i];
    end
  endfunction

  task automatic tick(input logic [3:0] kn);
    key_n = kn;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(kn);
    #1;
    chk("flags", {key_flag4, key_flag3, key_flag2, key_flag1}, exp_flag);
    chk("key_state", key_state, exp_state);
    if (key_flag1) pulses[0]++;
    if (key_flag2) pulses[1]++;
    if (key_flag3) pulses[2]++;
    if (key_flag4) pulses[3]++;
  endtask

  task automatic ticks(input logic [3:0] kn, input int n);
    for (int k = 0; k < n; k++) tick(kn);
  endtask

  task automatic clr_pulses();
    for (int i = 0; i < 4; i++) pulses[i] = 0;
  endtask

  initial begin
    int first;
    logic [3:0] kr;
    model_reset();
    // reset held with all keys pressed: outputs stay quiet
    ticks(4'b0000, 6);
    rst = 1'b0;
    ticks(4'b1111, 10);

    // single press of key0
    clr_pulses();
    ticks(4'b1110, 8);
    ticks(4'b1111, 20);
    chk("s2_flag1_cnt", pulses[0], 1);
    chk("s2_other_cnt", pulses[1] + pulses[2] + pulses[3], 0);

    // press bounce then long hold of key1 with repeats
    clr_pulses();
    ticks(4'b1101, 3);
    ticks(4'b1111, 1);
    ticks(4'b1101, 28);
    ticks(4'b1111, 14);
    chk("s3_flag2_cnt", pulses[1], 4);

    // simultaneous key2/key3
    clr_pulses();
    ticks(4'b0011, 8);
    ticks(4'b1111, 15);
    chk("s4_flag3_cnt", pulses[2], 1);
    chk("s4_flag4_cnt", pulses[3], 1);

    // release bounce while held
    clr_pulses();
    ticks(4'b1110, 10);
    ticks(4'b1111, 2);
    ticks(4'b1110, 12);
    chk("s5_flag1_cnt", pulses[0], 1);
    ticks(4'b1111, 15);

    // async reset mid-repeat, key0 still held afterwards
    ticks(4'b1110, 30);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_flags", {key_flag4, key_flag3, key_flag2, key_flag1}, 4'b0000);
    chk("async_rst_state", key_state, 4'b0000);
    model_reset();
    ticks(4'b1110, 3);
    rst = 1'b0;
    first = -1;
    for (int k = 0; k < 10; k++) begin
      tick(4'b1110);
      if (key_flag1 && first < 0) first = k;
    end
    chk("rearm_latency", first, 6);
    ticks(4'b1111, 15);

    // randomized traffic with occasional resets
    kr = 4'b1111;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 11) == 0) kr[i] = ~kr[i];
      if (!rst && $urandom_range(0, 599) == 0) rst = 1'b1;
      else if (rst && $urandom_range(0, 2) == 0) rst = 1'b0;
      tick(kr);
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
